// File: rtl/fir_pipe_sat.sv
// Pipelined single-MAC FIR engine with runtime tap count, output shift and saturation.
// AXI-Lite configuration, AXI-Stream in/out, external tap and data BRAMs with 1-cycle reads.
module fir_pipe_sat #(
  parameter int unsigned pADDR_WIDTH = 12,
  parameter int unsigned pDATA_WIDTH = 32,
  parameter int unsigned MAX_TAPS    = 32,
  parameter int unsigned ACC_WIDTH   = 2*pDATA_WIDTH+8
) (
  input  logic                   axis_clk,
  input  logic                   axis_rst,
  input  logic                   awvalid,
  output logic                   awready,
  input  logic [pADDR_WIDTH-1:0] awaddr,
  input  logic                   wvalid,
  output logic                   wready,
  input  logic [pDATA_WIDTH-1:0] wdata,
  input  logic                   arvalid,
  output logic                   arready,
  input  logic [pADDR_WIDTH-1:0] araddr,
  output logic                   rvalid,
  input  logic                   rready,
  output logic [pDATA_WIDTH-1:0] rdata,
  input  logic                   ss_tvalid,
  input  logic                   ss_tlast,
  input  logic [pDATA_WIDTH-1:0] ss_tdata,
  output logic                   ss_tready,
  output logic                   sm_tvalid,
  output logic                   sm_tlast,
  output logic [pDATA_WIDTH-1:0] sm_tdata,
  input  logic                   sm_tready,
  output logic                   tap_EN,
  output logic [3:0]             tap_WE,
  output logic [pADDR_WIDTH-1:0] tap_A,
  output logic [pDATA_WIDTH-1:0] tap_Di,
  input  logic [pDATA_WIDTH-1:0] tap_Do,
  output logic                   data_EN,
  output logic [3:0]             data_WE,
  output logic [pADDR_WIDTH-1:0] data_A,
  output logic [pDATA_WIDTH-1:0] data_Di,
  input  logic [pDATA_WIDTH-1:0] data_Do
);

  localparam int unsigned D  = pDATA_WIDTH;
  localparam int unsigned A  = pADDR_WIDTH;
  localparam int unsigned NW = $clog2(MAX_TAPS + 1);
  localparam int unsigned CW = NW + 1;
  localparam logic [A-1:0] TapBase = A'('h80);
  localparam logic [A-1:0] TapEnd  = A'('h80 + 4*MAX_TAPS);
  localparam logic signed [ACC_WIDTH-1:0] SatMax =
      {{(ACC_WIDTH-D+1){1'b0}}, {(D-1){1'b1}}};
  localparam logic signed [ACC_WIDTH-1:0] SatMin =
      {{(ACC_WIDTH-D+1){1'b1}}, {(D-1){1'b0}}};

  typedef enum logic [2:0] {StIdle, StClr, StWait, StMac, StOut} state_e;

  state_e                        r_state;
  logic                          r_wack, r_arready, r_rd_busy, r_rd_stage, r_rd_tapok, r_rvalid;
  logic [A-1:0]                  r_rd_addr;
  logic [D-1:0]                  r_rdata, r_len, r_out_count;
  logic                          r_done, r_err;
  logic [NW-1:0]                 r_ntap, r_wptr;
  logic [5:0]                    r_shift;
  logic [CW-1:0]                 r_cnt;
  logic                          r_v1, r_v2;
  logic signed [2*D-1:0]         r_prod;
  logic signed [ACC_WIDTH-1:0]   r_acc;

  logic                  w_idle, w_wack_d, w_ar_d, w_wr_tap, w_rd_tap, w_start;
  logic                  w_issue, w_last_out;
  logic [CW-1:0]         w_n, w_wp, w_didx;
  logic [D-1:0]          w_rd_val;
  logic signed [ACC_WIDTH-1:0] w_shifted;

  assign w_idle     = (r_state == StIdle);
  assign w_wack_d   = awvalid && wvalid && !r_wack;
  // A read is never launched in the cycle a write owns the tap port.
  assign w_ar_d     = arvalid && !r_rd_busy && !r_arready && !w_wack_d;
  assign w_wr_tap   = r_wack && (awaddr >= TapBase) && (awaddr < TapEnd);
  assign w_rd_tap   = (araddr >= TapBase) && (araddr < TapEnd);
  assign w_start    = r_wack && (awaddr == '0) && wdata[0] && w_idle;
  assign w_n        = {1'b0, r_ntap};
  assign w_wp       = {1'b0, r_wptr};
  assign w_issue    = (r_state == StMac) && (r_cnt < w_n);
  assign w_didx     = (w_wp >= r_cnt) ? (w_wp - r_cnt) : (w_wp + w_n - r_cnt);
  assign w_last_out = (r_out_count == (r_len - D'(1)));
  assign w_shifted  = r_acc >>> r_shift;

  assign awready   = r_wack;
  assign wready    = r_wack;
  assign arready   = r_arready;
  assign rvalid    = r_rvalid;
  assign rdata     = r_rdata;
  assign ss_tready = (r_state == StWait);
  assign sm_tvalid = (r_state == StOut);
  assign sm_tlast  = sm_tvalid && w_last_out;

  always_comb begin
    if (w_shifted > SatMax)      sm_tdata = SatMax[D-1:0];
    else if (w_shifted < SatMin) sm_tdata = SatMin[D-1:0];
    else                         sm_tdata = w_shifted[D-1:0];
  end

  always_comb begin
    w_rd_val = '0;
    if ((r_rd_addr >= TapBase) && (r_rd_addr < TapEnd)) begin
      w_rd_val = r_rd_tapok ? tap_Do : '1;
    end else begin
      case (r_rd_addr)
        A'('h00): w_rd_val = D'({r_err, w_idle, r_done, 1'b0});
        A'('h10): w_rd_val = r_len;
        A'('h14): w_rd_val = D'(r_ntap);
        A'('h18): w_rd_val = D'(r_shift);
        A'('h1C): w_rd_val = r_out_count;
        default:  w_rd_val = '0;
      endcase
    end
  end

  always_comb begin
    tap_EN = 1'b0;
    tap_WE = 4'h0;
    tap_A  = '0;
    tap_Di = '0;
    if (w_idle) begin
      if (w_wr_tap) begin
        tap_EN = 1'b1;
        tap_WE = 4'hF;
        tap_A  = awaddr - TapBase;
        tap_Di = wdata;
      end else if (r_arready && w_rd_tap) begin
        tap_EN = 1'b1;
        tap_A  = araddr - TapBase;
      end
    end else if (w_issue) begin
      tap_EN = 1'b1;
      tap_A  = A'({r_cnt, 2'b00});
    end
  end

  always_comb begin
    data_EN = 1'b0;
    data_WE = 4'h0;
    data_A  = '0;
    data_Di = '0;
    case (r_state)
      StClr: begin
        data_EN = 1'b1;
        data_WE = 4'hF;
        data_A  = A'({r_cnt, 2'b00});
      end
      StWait: begin
        if (ss_tvalid) begin
          data_EN = 1'b1;
          data_WE = 4'hF;
          data_A  = A'({r_wptr, 2'b00});
          data_Di = ss_tdata;
        end
      end
      StMac: begin
        if (w_issue) begin
          data_EN = 1'b1;
          data_A  = A'({w_didx, 2'b00});
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge axis_clk) begin
    if (axis_rst) begin
      r_state     <= StIdle;
      r_wack      <= 1'b0;
      r_arready   <= 1'b0;
      r_rd_busy   <= 1'b0;
      r_rd_stage  <= 1'b0;
      r_rd_tapok  <= 1'b0;
      r_rvalid    <= 1'b0;
      r_rd_addr   <= '0;
      r_rdata     <= '0;
      r_len       <= '0;
      r_out_count <= '0;
      r_done      <= 1'b0;
      r_err       <= 1'b0;
      r_ntap      <= NW'(MAX_TAPS);
      r_wptr      <= '0;
      r_shift     <= '0;
      r_cnt       <= '0;
      r_v1        <= 1'b0;
      r_v2        <= 1'b0;
      r_prod      <= '0;
      r_acc       <= '0;
    end else begin
      r_wack    <= w_wack_d;
      r_arready <= w_ar_d;

      if (r_arready) begin
        r_rd_busy  <= 1'b1;
        r_rd_addr  <= araddr;
        r_rd_tapok <= w_idle;
        r_rd_stage <= 1'b1;
      end
      if (r_rd_stage) begin
        r_rd_stage <= 1'b0;
        r_rvalid   <= 1'b1;
        r_rdata    <= w_rd_val;
      end
      if (r_rvalid && rready) begin
        r_rvalid  <= 1'b0;
        r_rd_busy <= 1'b0;
        if (r_rd_addr == '0) begin
          r_done <= 1'b0;
          r_err  <= 1'b0;
        end
      end

      if (r_wack && w_idle) begin
        case (awaddr)
          A'('h10): r_len   <= wdata;
          A'('h14): r_ntap  <= ((wdata == '0) || (wdata > D'(MAX_TAPS))) ? NW'(MAX_TAPS)
                                                                         : NW'(wdata);
          A'('h18): r_shift <= wdata[5:0];
          default: ;
        endcase
      end

      // Read -> product -> accumulate, one tap per cycle.
      r_v1 <= w_issue;
      r_v2 <= r_v1;
      if (r_v1) begin
        r_prod <= $signed({{D{tap_Do[D-1]}}, tap_Do}) * $signed({{D{data_Do[D-1]}}, data_Do});
      end
      if (r_v2) begin
        r_acc <= r_acc + {{(ACC_WIDTH-2*D){r_prod[2*D-1]}}, r_prod};
      end

      case (r_state)
        StIdle: begin
          if (w_start) begin
            r_state     <= StClr;
            r_cnt       <= '0;
            r_wptr      <= '0;
            r_out_count <= '0;
            r_done      <= 1'b0;
            r_err       <= 1'b0;
            r_acc       <= '0;
          end
        end
        StClr: begin
          r_cnt <= r_cnt + CW'(1);
          if (r_cnt == (w_n - CW'(1))) begin
            r_cnt <= '0;
            if (r_len == '0) begin
              r_state <= StIdle;
              r_done  <= 1'b1;
            end else begin
              r_state <= StWait;
            end
          end
        end
        StWait: begin
          if (ss_tvalid) begin
            r_cnt   <= '0;
            r_state <= StMac;
            if (ss_tlast != w_last_out) r_err <= 1'b1;
          end
        end
        StMac: begin
          r_cnt <= r_cnt + CW'(1);
          // Last product lands in the accumulator two cycles after the last issue.
          if (r_cnt == (w_n + CW'(1))) r_state <= StOut;
        end
        StOut: begin
          if (sm_tready) begin
            r_out_count <= r_out_count + D'(1);
            r_wptr      <= (r_wptr == (r_ntap - NW'(1))) ? '0 : r_wptr + NW'(1);
            r_acc       <= '0;
            if (w_last_out) begin
              r_state <= StIdle;
              r_done  <= 1'b1;
            end else begin
              r_state <= StWait;
            end
          end
        end
        default: r_state <= StIdle;
      endcase
    end
  end

endmodule
